ysyx_23060025_lsu_axi: RTL and testbench

Parametrised load/store unit: the successor to the current 32-bit LSU, sitting between the execute stage and the AXI4-Lite data port of the core.
- Accepts one memory request at a time over a valid/ready handshake and issues a single AXI4-Lite read or write.
- Returns extended load data or a store completion over a back-pressurable response handshake.
- Adds 64-bit data path support, independent AW/W handshakes, misalignment detection, and bus-error reporting.

---
 rtl/ysyx_23060025_lsu_axi.sv | 216 +++++++++++++++++++++
 tb/tb_ysyx_23060025_lsu_axi.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_lsu_axi.sv
// Load/store unit: one request at a time onto an AXI4-Lite data port.
// Handles lane steering, load extension, misalignment and bus errors.
module ysyx_23060025_lsu_axi #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_LEN-1:0]   req_addr_i,
    input  logic                  req_wen_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [DATA_LEN-1:0]   req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_LEN-1:0]   rsp_rdata_o,
    output logic [1:0]            rsp_err_o,
    output logic [4:0]            rsp_rd_o,
    output logic [ADDR_LEN-1:0]   addr_r_addr_o,
    output logic [2:0]            addr_r_size_o,
    output logic                  addr_r_valid_o,
    input  logic                  addr_r_ready_i,
    input  logic [DATA_LEN-1:0]   r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    output logic [ADDR_LEN-1:0]   addr_w_addr_o,
    output logic [2:0]            addr_w_size_o,
    output logic                  addr_w_valid_o,
    input  logic                  addr_w_ready_i,
    output logic [DATA_LEN-1:0]   w_data_o,
    output logic [DATA_LEN/8-1:0] w_strb_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    input  logic [1:0]            bkwd_resp_i,
    input  logic                  bkwd_valid_i,
    output logic                  bkwd_ready_o
);

    localparam int STRB_W = DATA_LEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [DATA_LEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [4:0]            rd_q, rd_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_LEN-1:0]   rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;

    logic [OFF_W-1:0]      req_off;
    logic [2:0]            low_mask;
    logic                  size_bad;
    logic                  misaligned;
    logic [8:0]            byte_mask;
    logic [DATA_LEN-1:0]   one;
    logic [DATA_LEN-1:0]   ld_shift;
    logic [DATA_LEN-1:0]   ld_mask;
    logic [6:0]            ld_bits;
    logic                  ld_sign;
    logic [DATA_LEN-1:0]   ld_ext;
    logic                  aw_ok;
    logic                  w_ok;

    assign one = {{(DATA_LEN-1){1'b0}}, 1'b1};

    // Request-side decode: alignment and write lane placement
    assign req_off    = req_addr_i[OFF_W-1:0];
    assign low_mask   = (3'd1 << req_size_i) - 3'd1;
    assign size_bad   = (DATA_LEN == 32) && (req_size_i == 2'd3);
    assign misaligned = (|(req_addr_i[2:0] & low_mask)) | size_bad;
    assign byte_mask  = (9'd1 << (4'd1 << req_size_i)) - 9'd1;

    // Load-side extraction: shift the addressed lane down, then extend
    assign ld_shift = r_data_i >> {addr_q[OFF_W-1:0], 3'b000};
    assign ld_bits  = 7'd8 << size_q;
    assign ld_mask  = (one << ld_bits) - one;
    assign ld_sign  = |(ld_shift & (one << (ld_bits - 7'd1)));
    assign ld_ext   = (ld_shift & ld_mask)
                    | ({DATA_LEN{ld_sign & signed_q}} & ~ld_mask);

    assign aw_ok = aw_done_q | addr_w_ready_i;
    assign w_ok  = w_done_q | w_ready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rd_d      = rd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    size_d    = req_size_i;
                    signed_d  = req_signed_i;
                    wdata_d   = req_wdata_i << {req_off, 3'b000};
                    strb_d    = STRB_W'(byte_mask) << req_off;
                    rd_d      = req_rd_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    err_d     = 2'd0;
                    if (misaligned) begin
                        err_d   = 2'd2;
                        state_d = RESP;
                    end else if (req_wen_i) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (addr_r_ready_i) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (r_valid_i) begin
                    state_d = RESP;
                    if (r_resp_i != 2'd0) begin
                        err_d   = 2'd1;
                        rdata_d = '0;
                    end else begin
                        rdata_d = ld_ext;
                    end
                end
            end
            WR_REQ: begin
                // AW and W may finish in either order or together
                if (aw_ok && w_ok) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            WR_RESP: begin
                if (bkwd_valid_i) begin
                    state_d = RESP;
                    if (bkwd_resp_i != 2'd0) err_d = 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= 2'd0;
            signed_q  <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rd_q      <= 5'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rd_q      <= rd_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdata_o    = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o      = rsp_valid_o ? err_q : 2'd0;
    assign rsp_rd_o       = rd_q;

    assign addr_r_valid_o = (state_q == RD_ADDR);
    assign addr_r_addr_o  = addr_r_valid_o ? addr_q : '0;
    assign addr_r_size_o  = addr_r_valid_o ? {1'b0, size_q} : 3'd0;
    assign r_ready_o      = (state_q == RD_DATA);

    assign addr_w_valid_o = (state_q == WR_REQ) && !aw_done_q;
    assign addr_w_addr_o  = addr_w_valid_o ? addr_q : '0;
    assign addr_w_size_o  = addr_w_valid_o ? {1'b0, size_q} : 3'd0;
    assign w_valid_o      = (state_q == WR_REQ) && !w_done_q;
    assign w_data_o       = w_valid_o ? wdata_q : '0;
    assign w_strb_o       = w_valid_o ? strb_q : '0;
    assign bkwd_ready_o   = (state_q == WR_RESP);

endmodule

// File: tb/tb_ysyx_23060025_lsu_axi.sv
// Directed bench for ysyx_23060025_lsu_axi: a 32-bit and a 64-bit instance.
module tb_ysyx_23060025_lsu_axi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit instance
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [4:0]  req_rd, rsp_rd;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic        ar_valid, ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid, r_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic        aw_valid, aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid, w_ready;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;

    // 64-bit instance
    logic        d_req_valid, d_req_ready, d_req_signed;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic [1:0]  d_req_size;
    logic [4:0]  d_rsp_rd;
    logic        d_rsp_valid, d_rsp_ready;
    logic [63:0] d_rsp_rdata;
    logic [1:0]  d_rsp_err;
    logic [31:0] d_ar_addr;
    logic [2:0]  d_ar_size;
    logic        d_ar_valid, d_ar_ready;
    logic [63:0] d_r_data;
    logic [1:0]  d_r_resp;
    logic        d_r_valid, d_r_ready;
    logic [31:0] d_aw_addr;
    logic [2:0]  d_aw_size;
    logic        d_aw_valid;
    logic [63:0] d_w_data;
    logic [7:0]  d_w_strb;
    logic        d_w_valid, d_b_ready;

    ysyx_23060025_lsu_axi #(.DATA_LEN(32), .ADDR_LEN(32)) u_lsu32 (
        .clock(clk), .reset(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wen_i(req_wen),
        .req_size_i(req_size), .req_signed_i(req_signed),
        .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_rd_o(rsp_rd),
        .addr_r_addr_o(ar_addr), .addr_r_size_o(ar_size),
        .addr_r_valid_o(ar_valid), .addr_r_ready_i(ar_ready),
        .r_data_i(r_data), .r_resp_i(r_resp),
        .r_valid_i(r_valid), .r_ready_o(r_ready),
        .addr_w_addr_o(aw_addr), .addr_w_size_o(aw_size),
        .addr_w_valid_o(aw_valid), .addr_w_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb),
        .w_valid_o(w_valid), .w_ready_i(w_ready),
        .bkwd_resp_i(b_resp), .bkwd_valid_i(b_valid), .bkwd_ready_o(b_ready)
    );

    ysyx_23060025_lsu_axi #(.DATA_LEN(64), .ADDR_LEN(32)) u_lsu64 (
        .clock(clk), .reset(rst),
        .req_valid_i(d_req_valid), .req_ready_o(d_req_ready),
        .req_addr_i(d_req_addr), .req_wen_i(1'b0),
        .req_size_i(d_req_size), .req_signed_i(d_req_signed),
        .req_wdata_i(d_req_wdata), .req_rd_i(5'd7),
        .rsp_valid_o(d_rsp_valid), .rsp_ready_i(d_rsp_ready),
        .rsp_rdata_o(d_rsp_rdata), .rsp_err_o(d_rsp_err), .rsp_rd_o(d_rsp_rd),
        .addr_r_addr_o(d_ar_addr), .addr_r_size_o(d_ar_size),
        .addr_r_valid_o(d_ar_valid), .addr_r_ready_i(d_ar_ready),
        .r_data_i(d_r_data), .r_resp_i(d_r_resp),
        .r_valid_i(d_r_valid), .r_ready_o(d_r_ready),
        .addr_w_addr_o(d_aw_addr), .addr_w_size_o(d_aw_size),
        .addr_w_valid_o(d_aw_valid), .addr_w_ready_i(1'b0),
        .w_data_o(d_w_data), .w_strb_o(d_w_strb),
        .w_valid_o(d_w_valid), .w_ready_i(1'b0),
        .bkwd_resp_i(2'd0), .bkwd_valid_i(1'b0), .bkwd_ready_o(d_b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load64(input string tag, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn,
                          input logic [63:0] data, input logic [1:0] resp,
                          input logic [63:0] exp_data, input logic [1:0] exp_err);
        d_req_valid = 1'b1; d_req_addr = addr;
        d_req_size = size; d_req_signed = sgn;
        tick();
        d_req_valid = 1'b0;
        check({tag, "_arv"}, d_ar_valid, 1'b1);
        check({tag, "_ara"}, d_ar_addr, addr);
        d_ar_ready = 1'b1;
        tick();
        d_ar_ready = 1'b0;
        d_r_valid = 1'b1; d_r_data = data; d_r_resp = resp;
        tick();
        d_r_valid = 1'b0;
        check({tag, "_rspv"}, d_rsp_valid, 1'b1);
        check({tag, "_data"}, d_rsp_rdata, exp_data);
        check({tag, "_err"}, d_rsp_err, exp_err);
        d_rsp_ready = 1'b1;
        tick();
        d_rsp_ready = 1'b0;
    endtask

    initial begin
        req_valid = 0; req_wen = 0; req_signed = 0; req_addr = 0;
        req_wdata = 0; req_size = 0; req_rd = 0; rsp_ready = 0;
        ar_ready = 0; r_data = 0; r_resp = 0; r_valid = 0;
        aw_ready = 0; w_ready = 0; b_resp = 0; b_valid = 0;
        d_req_valid = 0; d_req_signed = 0; d_req_addr = 0;
        d_req_wdata = 0; d_req_size = 0; d_rsp_ready = 0;
        d_ar_ready = 0; d_r_data = 0; d_r_resp = 0; d_r_valid = 0;

        tick(); tick();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_axi_valid", {ar_valid, aw_valid, w_valid}, 0);
        check("rst_axi_ready", {r_ready, b_ready}, 0);
        check("rst_w_strb", w_strb, 0);
        check("rst_d_req_ready", d_req_ready, 1'b1);
        rst = 1'b0;

        // signed byte load from the top lane
        req_valid = 1; req_addr = 32'h8000_0003; req_wen = 0;
        req_size = 0; req_signed = 1; req_rd = 5'd5;
        tick();
        req_valid = 0;
        check("lb_ar_valid", ar_valid, 1'b1);
        check("lb_ar_addr", ar_addr, 32'h8000_0003);
        check("lb_ar_size", ar_size, 3'd0);
        check("lb_req_ready", req_ready, 1'b0);
        ar_ready = 1;
        tick();
        ar_ready = 0;
        check("lb_ar_drop", ar_valid, 1'b0);
        check("lb_r_ready", r_ready, 1'b1);
        r_valid = 1; r_data = 32'h8012_3456; r_resp = 0;
        tick();
        r_valid = 0;
        check("lb_rsp_valid", rsp_valid, 1'b1);
        check("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        check("lb_err", rsp_err, 2'd0);
        check("lb_rd", rsp_rd, 5'd5);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("lb_idle_rspv", rsp_valid, 1'b0);
        check("lb_idle_ready", req_ready, 1'b1);

        // store half: AW accepted three cycles before W
        req_valid = 1; req_addr = 32'h8000_0002; req_wen = 1;
        req_size = 1; req_signed = 0; req_wdata = 32'h0000_BEEF; req_rd = 0;
        tick();
        req_valid = 0;
        check("sh_aw_valid", aw_valid, 1'b1);
        check("sh_w_valid", w_valid, 1'b1);
        check("sh_aw_addr", aw_addr, 32'h8000_0002);
        check("sh_aw_size", aw_size, 3'd1);
        check("sh_w_data", w_data, 32'hBEEF_0000);
        check("sh_w_strb", w_strb, 4'b1100);
        aw_ready = 1;
        tick();
        aw_ready = 0;
        check("sh_aw_drop", aw_valid, 1'b0);
        check("sh_aw_addr0", aw_addr, 0);
        check("sh_w_hold", w_valid, 1'b1);
        tick();
        check("sh_b_wait1", b_ready, 1'b0);
        tick();
        check("sh_b_wait2", b_ready, 1'b0);
        check("sh_w_hold2", w_data, 32'hBEEF_0000);
        w_ready = 1;
        tick();
        w_ready = 0;
        check("sh_w_drop", w_valid, 1'b0);
        check("sh_w_data0", w_data, 0);
        check("sh_b_ready", b_ready, 1'b1);
        b_valid = 1; b_resp = 0;
        tick();
        b_valid = 0;
        check("sh_rsp_valid", rsp_valid, 1'b1);
        check("sh_rsp_err", rsp_err, 2'd0);
        check("sh_rsp_rdata", rsp_rdata, 0);

        // back-pressure with a competing request pending
        req_valid = 1; req_wen = 0; req_size = 2; req_addr = 32'h8000_0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_no_ar", ar_valid, 1'b0);
        end
        req_valid = 0; rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("bp_released", {rsp_valid, req_ready}, 2'b01);

        // word store with AW/W together and a bus error on B
        req_valid = 1; req_addr = 32'h8000_0004; req_wen = 1;
        req_size = 2; req_wdata = 32'h1234_5678;
        tick();
        req_valid = 0;
        check("sw_w_data", w_data, 32'h1234_5678);
        check("sw_w_strb", w_strb, 4'b1111);
        aw_ready = 1; w_ready = 1;
        tick();
        aw_ready = 0; w_ready = 0;
        check("sw_both_done", {aw_valid, w_valid, b_ready}, 3'b001);
        b_valid = 1; b_resp = 2'd2;
        tick();
        b_valid = 0; b_resp = 0;
        check("sw_rsp_valid", rsp_valid, 1'b1);
        check("sw_err", rsp_err, 2'd1);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // misaligned word load
        req_valid = 1; req_addr = 32'h8000_0001; req_wen = 0;
        req_size = 2; req_signed = 0;
        tick();
        req_valid = 0;
        check("mis_rsp_valid", rsp_valid, 1'b1);
        check("mis_err", rsp_err, 2'd2);
        check("mis_rdata", rsp_rdata, 0);
        check("mis_no_ar", ar_valid, 1'b0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("mis_idle", {req_ready, ar_valid}, 2'b10);

        // reset while waiting for R
        req_valid = 1; req_addr = 32'h8000_0000; req_size = 2;
        tick();
        req_valid = 0; ar_ready = 1;
        tick();
        ar_ready = 0;
        check("rr_in_rdata", r_ready, 1'b1);
        rst = 1;
        tick();
        rst = 0;
        check("rr_r_ready", r_ready, 1'b0);
        check("rr_req_ready", req_ready, 1'b1);
        check("rr_rsp", {rsp_valid, rsp_err}, 3'b000);
        check("rr_rdata", rsp_rdata, 0);
        r_valid = 1; r_data = 32'hDEAD_BEEF;
        tick();
        r_valid = 0;
        check("rr_late_beat", rsp_valid, 1'b0);

        // 64-bit data path
        load64("ld_err", 32'h8000_0008, 2'd3, 1'b0,
               64'h1122_3344_5566_7788, 2'b10, 64'h0, 2'd1);
        load64("lwu_hi", 32'h8000_0004, 2'd2, 1'b0,
               64'h89AB_CDEF_0123_4567, 2'b00, 64'h0000_0000_89AB_CDEF, 2'd0);
        load64("lh_hi", 32'h8000_0006, 2'd1, 1'b1,
               64'h89AB_CDEF_0123_4567, 2'b00, 64'hFFFF_FFFF_FFFF_89AB, 2'd0);
        load64("ld_ok", 32'h8000_0000, 2'd3, 1'b1,
               64'h8000_0000_0000_0001, 2'b00, 64'h8000_0000_0000_0001, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
